// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer for a 4:1 bit mux. It steps the selects through channels 0..3 and holds each one
// for DWELL cycles, then delivers all four captured bits as one word with a valid pulse.
// Optional build macro: MUX4_SCAN_CONTINUOUS_EN (free-running scans after the first start).
module mux4_scan_ctrl #(
   parameter int DWELL = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       q,
   output logic       s1,
   output logic       s0,
   output logic [3:0] sample,
   output logic       valid,
   output logic       busy,
   output logic       state_dbg
);

   localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   state_t          state;
   logic [CW-1:0]   cnt;
   logic [1:0]      ch;
   logic [2:0]      shadow;
   logic            dwell_done;

   // With DWELL==1 every SCAN cycle closes a dwell and cnt stays at zero.
   assign dwell_done = (DWELL == 1) ? 1'b1 : (cnt == CNT_LAST);

   assign s1        = ch[1];
   assign s0        = ch[0];
   assign state_dbg = (state == SCAN);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         ch     <= 2'd0;
         shadow <= 3'b000;
         sample <= 4'b0000;
         valid  <= 1'b0;
         busy   <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= SCAN;
                  ch    <= 2'd0;
                  cnt   <= '0;
                  busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (dwell_done) begin
                  cnt <= '0;
                  if (ch != 2'd3) begin
                     shadow[ch] <= q;
                     ch         <= ch + 2'd1;
                  end else begin
                     // Channel 3 goes straight into sample so the word updates in one edge.
                     sample <= {q, shadow};
                     valid  <= 1'b1;
                     ch     <= 2'd0;
`ifdef MUX4_SCAN_CONTINUOUS_EN
                     state  <= SCAN;
                     busy   <= 1'b1;
`else
                     state  <= IDLE;
                     busy   <= 1'b0;
`endif
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
